elevator_plant: RTL and testbench

//   Behavioural plant for the elevator control project: the car, shaft, three doors
//   and the settle/start timer. It consumes the controller's command pulses
//   (MU/MD/CUE/CLE/CI/OUE/OLE/OI/KT) and produces its status inputs (UES/LES/IS/AU/AL/T).
//   It closes the loop for system simulation and FPGA demo, and flags unsafe commands.

---
 rtl/elevator_plant.sv | 111 +++++++++++
 tb/tb_elevator_plant.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/elevator_plant.sv
// elevator_plant: car, shaft, three doors and settle timer closing the loop around the elevator controller
module elevator_plant #(
  parameter int SHAFT_STEPS  = 8,
  parameter int DOOR_CYCLES  = 4,
  parameter int TIMER_CYCLES = 16,
  parameter int POS_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MU,
  input  logic             MD,
  input  logic             OUE,
  input  logic             OLE,
  input  logic             OI,
  input  logic             CUE,
  input  logic             CLE,
  input  logic             CI,
  input  logic             KT,
  output logic             UES,
  output logic             LES,
  output logic             IS,
  output logic             AU,
  output logic             AL,
  output logic             T,
  output logic [POS_W-1:0] pos,
  output logic             fault,
  output logic [2:0]       fault_code
);
  localparam logic [1:0] CLOSED = 2'd0, OPENING = 2'd1, OPEN = 2'd2, CLOSING = 2'd3;
  localparam int CW = $clog2(DOOR_CYCLES + 1);
  localparam int TW = $clog2(TIMER_CYCLES);
  localparam logic [CW-1:0] DC_LAST = CW'(DOOR_CYCLES - 1);
  localparam logic [POS_W-1:0] TOP = POS_W'(SHAFT_STEPS);
  localparam logic [1:0] OPEN_GO = (DOOR_CYCLES == 1) ? OPEN : OPENING;
  localparam logic [1:0] CLOSE_GO = (DOOR_CYCLES == 1) ? CLOSED : CLOSING;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic fault_q, fault_d;
  logic [2:0] code_q, code_d, cause;
  logic [2:0] open_c, close_c, door_closed, door_stat;
  logic ext_bad;
  assign AU = pos_q == TOP;
  assign AL = pos_q == '0;
  assign open_c = {OI, OLE & AL, OUE & AU};
  assign close_c = {CI, CLE & AL, CUE & AU};
  assign ext_bad = ((OUE || CUE) && !AU) || ((OLE || CLE) && !AL);
  // index 0 = upper exterior, 1 = lower exterior, 2 = internal
  for (genvar g = 0; g < 3; g++) begin : g_door
    logic [1:0] st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic stat_q, stat_d, done;
    always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      done = cnt_q + CW'(1) >= DC_LAST;
      if (open_c[g] && (st_q == CLOSED || st_q == CLOSING)) begin
        st_d = st_q == CLOSED ? OPEN_GO : OPENING;
        cnt_d = st_q == CLOSED ? '0 : DC_LAST - cnt_q;
      end else if (close_c[g] && !open_c[g] && (st_q == OPEN || st_q == OPENING)) begin
        st_d = st_q == OPEN ? CLOSE_GO : CLOSING;
        cnt_d = st_q == OPEN ? '0 : DC_LAST - cnt_q;
      end else if (st_q == OPENING || st_q == CLOSING) begin
        st_d = !done ? st_q : st_q == OPENING ? OPEN : CLOSED;
        cnt_d = done ? '0 : cnt_q + CW'(1);
      end
      stat_d = st_d == OPEN ? 1'b1 : st_d == CLOSED ? 1'b0 : stat_q;
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        st_q <= CLOSED;
        cnt_q <= '0;
        stat_q <= 1'b0;
      end else begin
        st_q <= st_d;
        cnt_q <= cnt_d;
        stat_q <= stat_d;
      end
    end
    assign door_closed[g] = st_q == CLOSED;
    assign door_stat[g] = stat_q;
  end
  assign {IS, LES, UES} = door_stat;
  always_comb begin
    cause = (MU && MD) ? 3'd2 :
            ((MU || MD) && !(&door_closed)) ? 3'd1 :
            ((MU && AU) || (MD && AL)) ? 3'd3 :
            ext_bad ? 3'd4 : 3'd0;
    pos_d = (MU && !MD && &door_closed && !AU) ? pos_q + POS_W'(1) :
            (MD && !MU && &door_closed && !AL) ? pos_q - POS_W'(1) : pos_q;
    fault_d = fault_q || cause != 3'd0;
    code_d = fault_q ? code_q : cause;
    tcnt_d = KT ? TW'(TIMER_CYCLES - 1) : tcnt_q == '0 ? tcnt_q : tcnt_q - TW'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      tcnt_q <= '0;
      fault_q <= 1'b0;
      code_q <= 3'd0;
    end else begin
      pos_q <= pos_d;
      tcnt_q <= tcnt_d;
      fault_q <= fault_d;
      code_q <= code_d;
    end
  end
  assign T = tcnt_q == '0;
  assign pos = pos_q;
  assign fault = fault_q;
  assign fault_code = code_q;
endmodule

// File: tb/tb_elevator_plant.sv
// tb_elevator_plant: directed scenario bench for the elevator plant
module tb_elevator_plant;
  logic clk = 0, reset = 0;
  logic MU = 0, MD = 0, OUE = 0, OLE = 0, OI = 0, CUE = 0, CLE = 0, CI = 0, KT = 0;
  logic UES, LES, IS, AU, AL, T, fault;
  logic [3:0] pos;
  logic [2:0] fault_code;
  int pass = 0, total = 0;
  elevator_plant dut (
    .clk(clk), .reset(reset), .MU(MU), .MD(MD), .OUE(OUE), .OLE(OLE), .OI(OI),
    .CUE(CUE), .CLE(CLE), .CI(CI), .KT(KT), .UES(UES), .LES(LES), .IS(IS),
    .AU(AU), .AL(AL), .T(T), .pos(pos), .fault(fault), .fault_code(fault_code)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    {MU, MD, OUE, OLE, OI, CUE, CLE, CI, KT} = '0;
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask
  task automatic test_reset;
    do_reset();
    for (int i = 0; i < 20; i++) tick();
    total++; if (pos !== 4'd0) $display("FAIL reset_pos got %0d want 0", pos); else pass++;
    total++; if (AL !== 1'b1) $display("FAIL reset_AL got %b want 1", AL); else pass++;
    total++; if (AU !== 1'b0) $display("FAIL reset_AU got %b want 0", AU); else pass++;
    total++; if ({UES, LES, IS} !== 3'b000) $display("FAIL reset_doors got %b want 000", {UES, LES, IS}); else pass++;
    total++; if (T !== 1'b1) $display("FAIL reset_T got %b want 1", T); else pass++;
    total++; if ({fault, fault_code} !== 4'd0) $display("FAIL reset_fault got %b/%0d want 0/0", fault, fault_code); else pass++;
  endtask
  task automatic test_timer;
    KT = 1;
    tick();
    KT = 0;
    for (int k = 1; k <= 15; k++) begin
      total++; if (T !== 1'b0) $display("FAIL timer_low cycle n+%0d got %b want 0", k, T); else pass++;
      if (k < 15) tick();
    end
    tick();
    total++; if (T !== 1'b1) $display("FAIL timer_rise got %b want 1", T); else pass++;
    KT = 1;
    for (int k = 0; k < 5; k++) tick();
    KT = 0;
    for (int k = 1; k <= 15; k++) begin
      total++; if (T !== 1'b0) $display("FAIL timer_held_low cycle m+%0d got %b want 0", k, T); else pass++;
      if (k < 15) tick();
    end
    tick();
    total++; if (T !== 1'b1) $display("FAIL timer_held_rise got %b want 1", T); else pass++;
  endtask
  task automatic test_doors;
    do_reset();
    OLE = 1; OI = 1;
    tick();
    OLE = 0; OI = 0;
    for (int k = 1; k <= 3; k++) begin
      total++; if ({LES, IS} !== 2'b00) $display("FAIL open_travel n+%0d got %b want 00", k, {LES, IS}); else pass++;
      tick();
    end
    total++; if ({LES, IS} !== 2'b11) $display("FAIL open_done got %b want 11", {LES, IS}); else pass++;
    tick();
    tick();
    CLE = 1; CI = 1;
    tick();
    CLE = 0; CI = 0;
    for (int k = 1; k <= 3; k++) begin
      total++; if ({LES, IS} !== 2'b11) $display("FAIL close_travel m+%0d got %b want 11", k, {LES, IS}); else pass++;
      tick();
    end
    total++; if ({LES, IS} !== 2'b00) $display("FAIL close_done got %b want 00", {LES, IS}); else pass++;
    total++; if (fault !== 1'b0) $display("FAIL door_nofault got %b want 0", fault); else pass++;
  endtask
  task automatic test_reverse;
    do_reset();
    OLE = 1;
    tick();
    OLE = 0; CLE = 1;
    tick();
    CLE = 0;
    total++; if (LES !== 1'b0) $display("FAIL reverse_les got %b want 0", LES); else pass++;
    tick();
    MU = 1;
    tick();
    MU = 0;
    total++; if (pos !== 4'd1) $display("FAIL reverse_closed_move got pos %0d want 1", pos); else pass++;
    total++; if (fault !== 1'b0) $display("FAIL reverse_nofault got %b want 0", fault); else pass++;
    for (int k = 0; k < 4; k++) tick();
    total++; if (LES !== 1'b0) $display("FAIL reverse_les_late got %b want 0", LES); else pass++;
  endtask
  task automatic test_travel;
    do_reset();
    MU = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++; if (pos !== 4'(i)) $display("FAIL travel_pos step %0d got %0d want %0d", i, pos, i); else pass++;
      total++; if (AU !== (i == 8)) $display("FAIL travel_AU step %0d got %b want %b", i, AU, i == 8); else pass++;
    end
    total++; if (fault !== 1'b0) $display("FAIL travel_nofault got %b want 0", fault); else pass++;
    tick();
    MU = 0;
    total++; if (pos !== 4'd8) $display("FAIL overtravel_pos got %0d want 8", pos); else pass++;
    total++; if ({fault, fault_code} !== {1'b1, 3'd3}) $display("FAIL overtravel_code got %b/%0d want 1/3", fault, fault_code); else pass++;
  endtask
  task automatic test_door_fault;
    do_reset();
    OI = 1;
    tick();
    OI = 0;
    for (int k = 0; k < 3; k++) tick();
    total++; if (IS !== 1'b1) $display("FAIL inner_open got %b want 1", IS); else pass++;
    MD = 1;
    tick();
    MD = 0;
    total++; if (pos !== 4'd0) $display("FAIL door_move_pos got %0d want 0", pos); else pass++;
    total++; if ({fault, fault_code} !== {1'b1, 3'd1}) $display("FAIL door_move_code got %b/%0d want 1/1", fault, fault_code); else pass++;
    MU = 1; MD = 1;
    tick();
    MU = 0; MD = 0;
    total++; if (fault_code !== 3'd1) $display("FAIL sticky_code got %0d want 1", fault_code); else pass++;
    total++; if (IS !== 1'b1) $display("FAIL inner_held got %b want 1", IS); else pass++;
  endtask
  task automatic test_ext_fault;
    do_reset();
    OUE = 1;
    tick();
    OUE = 0;
    total++; if ({fault, fault_code} !== {1'b1, 3'd4}) $display("FAIL ext_code got %b/%0d want 1/4", fault, fault_code); else pass++;
    for (int k = 0; k < 5; k++) tick();
    total++; if (UES !== 1'b0) $display("FAIL ext_ignored got %b want 0", UES); else pass++;
  endtask
  task automatic test_reset_mid;
    do_reset();
    OLE = 1;
    tick();
    OLE = 0;
    tick();
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    total++; if (LES !== 1'b0) $display("FAIL mid_reset_les got %b want 0", LES); else pass++;
    total++; if (fault !== 1'b0) $display("FAIL mid_reset_fault got %b want 0", fault); else pass++;
  endtask
  initial begin
    test_reset();
    test_timer();
    test_doors();
    test_reverse();
    test_travel();
    test_door_fault();
    test_ext_fault();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
